fetch_unit: RTL

- Instruction-fetch responder on the far side of the control FSM's fetch strobe.
- Owns the program counter, issues word reads to instruction memory and captures the returned instruction.
- Presents OPCODE/MM fields to the controller with a valid flag, and applies absolute/relative branch updates.
- Sits between `ctrl` and the instruction memory port; replaces the bare PC register in the datapath.

---
 rtl/isa_pkg.sv | 41 ++++
 rtl/pc_next.sv | 26 ++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode values, instruction field positions and the
// fetch state encoding used by the fetch responder.
package isa_pkg;

   // Opcode values carried in the top nibble of every instruction word
   localparam logic [3:0] OP_NOOP = 4'h0;
   localparam logic [3:0] OP_LOD  = 4'h1;
   localparam logic [3:0] OP_STR  = 4'h2;
   localparam logic [3:0] OP_BRA  = 4'h4;
   localparam logic [3:0] OP_BRR  = 4'h5;
   localparam logic [3:0] OP_BNE  = 4'h6;
   localparam logic [3:0] OP_ALU  = 4'h8;
   localparam logic [3:0] OP_HLT  = 4'hF;

   // Instruction word layout
   localparam int INSTR_W    = 32;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;
   localparam int MM_MSB     = 27;
   localparam int MM_LSB     = 24;

   // Addressing-mode value selecting an immediate operand
   localparam logic [3:0] AM_IMM = 4'h8;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2,
      FS_HOLD = 2'd3
   } fetch_state_t;

   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [3:0] mm_of(input logic [INSTR_W-1:0] word);
      return word[MM_MSB:MM_LSB];
   endfunction

endpackage

// File: rtl/pc_next.sv
// Next program-counter selector: hold, increment, absolute or relative branch.
// A branch always wins over the increment; relative arithmetic wraps at PC_W.
module pc_next #(
   parameter int PC_W = 16
) (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] rel_base,
   input  logic [PC_W-1:0] br_target,
   input  logic            incr,
   input  logic            br_en,
   input  logic            br_mode,
   output logic [PC_W-1:0] next_pc
);

   // Select the PC value to be loaded at the next edge
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves next_pc unassigned (otherwise a latch is inferred).
      next_pc = pc;
      if (br_en) begin
         next_pc = br_mode ? (rel_base + br_target) : br_target;
      end else if (incr) begin
         next_pc = pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: owns the PC, issues one instruction-memory read
// per fetch request, captures the returned word and applies branch updates.
module fetch_unit
   import isa_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                FETCH_REQ,
   input  logic                BR_TAKE,
   input  logic                BR_MODE,
   input  logic [PC_W-1:0]     BR_TARGET,
   output logic                IMEM_REQ,
   output logic [PC_W-1:0]     IMEM_ADDR,
   input  logic                IMEM_RVALID,
   input  logic [INSTR_W-1:0]  IMEM_RDATA,
   output logic [INSTR_W-1:0]  INSTR,
   output logic [3:0]          OPCODE,
   output logic [3:0]          MM,
   output logic [PC_W-1:0]     INSTR_PC,
   output logic                INSTR_VALID,
   output logic                BUSY,
   output logic                HALTED
);

   fetch_state_t    state;
   logic [PC_W-1:0] pc;

   // Branch requested while a fetch is outstanding, applied at capture
   logic            pend_valid;
   logic            pend_mode;
   logic [PC_W-1:0] pend_target;

   logic            capture;
   logic            idle_or_hold;
   logic            start_fetch;

   logic            sel_incr;
   logic            sel_br_en;
   logic            sel_mode;
   logic [PC_W-1:0] sel_target;
   logic [PC_W-1:0] sel_rel_base;
   logic [PC_W-1:0] next_pc;

   assign capture      = (state == FS_WAIT) && IMEM_RVALID;
   assign idle_or_hold = (state == FS_IDLE) || (state == FS_HOLD);
   assign start_fetch  = idle_or_hold && FETCH_REQ && !HALTED;

   // Steer the next-PC mux: capture increments (a fresh or pending branch overrides),
   // idle/hold applies a direct branch relative to the held instruction's address
   always_comb begin
      sel_incr     = 1'b0;
      sel_br_en    = 1'b0;
      sel_mode     = BR_MODE;
      sel_target   = BR_TARGET;
      sel_rel_base = INSTR_PC;
      if (capture) begin
         sel_incr     = 1'b1;
         sel_rel_base = pc;
         if (BR_TAKE) begin
            sel_br_en = 1'b1;
         end else if (pend_valid) begin
            sel_br_en  = 1'b1;
            sel_mode   = pend_mode;
            sel_target = pend_target;
         end
      end else if (idle_or_hold) begin
         sel_br_en = BR_TAKE;
      end
   end

   pc_next #(
      .PC_W (PC_W)
   ) u_pc_next (
      .pc        (pc),
      .rel_base  (sel_rel_base),
      .br_target (sel_target),
      .incr      (sel_incr),
      .br_en     (sel_br_en),
      .br_mode   (sel_mode),
      .next_pc   (next_pc)
   );

   // Fetch sequencer with registered memory strobe, captured instruction and status
   always_ff @(posedge CLK) begin
      if (RST) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state       <= FS_IDLE;
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_mode   <= 1'b0;
         pend_target <= '0;
         IMEM_REQ    <= 1'b0;
         IMEM_ADDR   <= '0;
         INSTR       <= '0;
         INSTR_PC    <= '0;
         INSTR_VALID <= 1'b0;
         BUSY        <= 1'b0;
         HALTED      <= 1'b0;
      end else begin
         pc <= next_pc;
         case (state)
            FS_IDLE, FS_HOLD: begin
               if (start_fetch) begin
                  state       <= FS_REQ;
                  IMEM_REQ    <= 1'b1;
                  IMEM_ADDR   <= next_pc;
                  BUSY        <= 1'b1;
                  INSTR_VALID <= 1'b0;
               end
            end
            FS_REQ: begin
               IMEM_REQ <= 1'b0;
               state    <= FS_WAIT;
               if (BR_TAKE) begin
                  pend_valid  <= 1'b1;
                  pend_mode   <= BR_MODE;
                  pend_target <= BR_TARGET;
               end
            end
            FS_WAIT: begin
               if (capture) begin
                  INSTR       <= IMEM_RDATA;
                  INSTR_PC    <= pc;
                  INSTR_VALID <= 1'b1;
                  BUSY        <= 1'b0;
                  pend_valid  <= 1'b0;
                  state       <= FS_HOLD;
                  if (opcode_of(IMEM_RDATA) == OP_HLT) begin
                     HALTED <= 1'b1;
                  end
               end else if (BR_TAKE) begin
                  pend_valid  <= 1'b1;
                  pend_mode   <= BR_MODE;
                  pend_target <= BR_TARGET;
               end
            end
            default: state <= FS_IDLE;
         endcase
      end
   end

   assign OPCODE = opcode_of(INSTR);
   assign MM     = mm_of(INSTR);

endmodule
